shift_out_arbiter: RTL and testbench

SHIFT_OUT_ARBITER -- requirements
Module: shift_out_arbiter

---
 rtl/shift_out_arbiter.sv | 124 ++++++++++++
 tb/tb_shift_out_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_out_arbiter.sv
// Two-requester round-robin arbiter feeding a serial shift-register chain (data/clock/latch).
// Build option: define SOA_LSB_FIRST_EN to shift frames LSB first; the default is MSB first.
module shift_out_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 8
) (
  input  logic             CLK_i,
  input  logic             RST_ni,
  input  logic             req_a_i,
  input  logic [WIDTH-1:0] data_a_i,
  output logic             gnt_a_o,
  input  logic             req_b_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             gnt_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ser_data_o,
  output logic             ser_clk_o,
  output logic             ser_latch_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       div_q;
  logic [5:0]       bit_q;
  logic [WIDTH-1:0] sr_q;
  logic             last_b_q;
  logic             div_last, bit_last;
  logic             gnt_a, gnt_b;
  logic             cur_bit;

  assign div_last = (div_q == DIV_LAST);
  assign bit_last = (bit_q == BIT_LAST);

`ifdef SOA_LSB_FIRST_EN
  assign cur_bit = sr_q[0];
`else
  assign cur_bit = sr_q[WIDTH-1];
`endif

  // Handshake: a requester holds req high until it sees its one-cycle gnt pulse; the
  // grant can only fire in IDLE, and data is captured on the clock edge ending that cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == IDLE && RST_ni) begin
      if (req_a_i && (!req_b_i || last_b_q)) gnt_a = 1'b1;
      else if (req_b_i)                      gnt_b = 1'b1;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_a || gnt_b) state_d = SHIFT_LO;
      SHIFT_LO: if (div_last)       state_d = SHIFT_HI;
      SHIFT_HI: if (div_last)       state_d = bit_last ? LATCH : SHIFT_LO;
      LATCH:    if (div_last)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    ser_clk_o   = (state_q == SHIFT_HI);
    ser_latch_o = (state_q == LATCH);
    ser_data_o  = (state_q == SHIFT_LO || state_q == SHIFT_HI) ? cur_bit : 1'b0;
    done_o      = (state_q == LATCH) && div_last;
    gnt_a_o     = gnt_a;
    gnt_b_o     = gnt_b;
    dbg_state_o = state_q;
  end

  // Every state change happens on div_last, so the divider simply wraps per phase.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      div_q <= 8'd0;
      bit_q <= 6'd0;
    end else if (state_q == IDLE) begin
      div_q <= 8'd0;
      bit_q <= 6'd0;
    end else begin
      div_q <= div_last ? 8'd0 : div_q + 8'd1;
      if (state_q == SHIFT_HI && div_last) bit_q <= bit_last ? 6'd0 : bit_q + 6'd1;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      sr_q     <= '0;
      last_b_q <= 1'b1;
    end else begin
      if (gnt_a) begin
        sr_q     <= data_a_i;
        last_b_q <= 1'b0;
      end else if (gnt_b) begin
        sr_q     <= data_b_i;
        last_b_q <= 1'b1;
      end else if (state_q == SHIFT_HI && div_last) begin
`ifdef SOA_LSB_FIRST_EN
        sr_q <= sr_q >> 1;
`else
        sr_q <= sr_q << 1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_out_arbiter.sv
// Directed bench for shift_out_arbiter: an 8-bit CLK_DIV=2 instance and a 4-bit CLK_DIV=1 instance.
module tb_shift_out_arbiter;

  logic       clk, rst_n;
  logic       req_a, req_b, req_a4;
  logic [7:0] data_a, data_b;
  logic [3:0] data_a4;
  logic       gnt_a, gnt_b, busy, done, ser_data, ser_clk, ser_latch;
  logic [1:0] dbg_state;
  logic       gnt_a4, gnt_b4, busy4, done4, ser_data4, ser_clk4, ser_latch4;
  logic [1:0] dbg_state4;
  logic       sel;
  logic       m_busy, m_done, m_data, m_clk, m_latch, m_gnt_a, m_gnt_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_n, done_n, latch_n, gnt_a_n, gnt_b_n, done_at, rst_seen;
  logic        timed_out;
  logic [31:0] clk_trace;
  logic [0:0]  exp_q[$];
  logic [0:0]  cap_q[$];

  shift_out_arbiter #(.CLK_DIV(2), .WIDTH(8)) u_dut (
    .CLK_i(clk), .RST_ni(rst_n),
    .req_a_i(req_a), .data_a_i(data_a), .gnt_a_o(gnt_a),
    .req_b_i(req_b), .data_b_i(data_b), .gnt_b_o(gnt_b),
    .busy_o(busy), .done_o(done), .ser_data_o(ser_data), .ser_clk_o(ser_clk),
    .ser_latch_o(ser_latch), .dbg_state_o(dbg_state)
  );

  shift_out_arbiter #(.CLK_DIV(1), .WIDTH(4)) u_dut4 (
    .CLK_i(clk), .RST_ni(rst_n),
    .req_a_i(req_a4), .data_a_i(data_a4), .gnt_a_o(gnt_a4),
    .req_b_i(1'b0), .data_b_i(4'h0), .gnt_b_o(gnt_b4),
    .busy_o(busy4), .done_o(done4), .ser_data_o(ser_data4), .ser_clk_o(ser_clk4),
    .ser_latch_o(ser_latch4), .dbg_state_o(dbg_state4)
  );

  assign m_busy  = sel ? busy4      : busy;
  assign m_done  = sel ? done4      : done;
  assign m_data  = sel ? ser_data4  : ser_data;
  assign m_clk   = sel ? ser_clk4   : ser_clk;
  assign m_latch = sel ? ser_latch4 : ser_latch;
  assign m_gnt_a = sel ? gnt_a4     : gnt_a;
  assign m_gnt_b = sel ? gnt_b4     : gnt_b;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input int w);
    for (int i = 0; i < w; i++) begin
`ifdef SOA_LSB_FIRST_EN
      exp_q.push_back(d[i]);
`else
      exp_q.push_back(d[w-1-i]);
`endif
    end
  endtask

  task automatic check_bits(input string tag);
    check({tag, "_nbits"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0)
      check({tag, "_bit"}, 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    cap_q.delete();
  endtask

  // Samples every falling edge until the frame has been busy and returned to IDLE.
  task automatic watch(input int budget);
    logic prev_clk, seen, ended;
    busy_n = 0; done_n = 0; latch_n = 0; gnt_a_n = 0; gnt_b_n = 0; done_at = 0;
    clk_trace = '0; cap_q.delete();
    prev_clk = 1'b0; seen = 1'b0; ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      @(negedge clk);
      if (m_busy) begin
        seen = 1'b1;
        busy_n++;
        clk_trace = {clk_trace[30:0], m_clk};
        if (m_gnt_a) gnt_a_n++;
        if (m_gnt_b) gnt_b_n++;
      end
      if (m_latch) latch_n++;
      if (m_done) begin
        done_n++;
        done_at = busy_n;
      end
      if (m_clk && !prev_clk) cap_q.push_back(m_data);
      prev_clk = m_clk;
      if (seen && !m_busy) ended = 1'b1;
    end
    timed_out = !ended;
  endtask

  task automatic check_full_frame(input string tag, input logic [31:0] d);
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_busy"},    32'(busy_n),    32'd34);
    check({tag, "_latch"},   32'(latch_n),   32'd2);
    check({tag, "_done"},    32'(done_n),    32'd1);
    check({tag, "_done_at"}, 32'(done_at),   32'd34);
    push_exp(d, 8);
    check_bits(tag);
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    req_a = 1'b1; data_a = 8'hA5;
    req_b = 1'b0; data_b = 8'h00;
    req_a4 = 1'b0; data_a4 = 4'h0;
    tick();
    tick();
    check("rst_outs", {25'd0, busy, ser_clk, ser_data, ser_latch, done, gnt_a, gnt_b}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);

    // A alone with 0xA5: expect serial 1,0,1,0,0,1,0,1
    rst_n = 1'b1;
    @(negedge clk);
    check("a5_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
    check("a5_idle_busy", 32'(busy), 32'd0);
    tick();
    req_a = 1'b0;
    watch(100);
    check_full_frame("a5", 32'hA5);
    check("a5_gnt_during", 32'(gnt_a_n + gnt_b_n), 32'd0);
    check("idle_outs", {29'd0, ser_data, ser_clk, ser_latch}, 32'd0);

    // simultaneous requests right after reset: A wins, B follows one cycle after done
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req_a = 1'b1; data_a = 8'h0F;
    req_b = 1'b1; data_b = 8'hF0;
    @(negedge clk);
    check("both_first", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    req_a = 1'b0;
    watch(100);
    check_full_frame("a0f", 32'h0F);
    check("b_held_no_gnt", 32'(gnt_b_n), 32'd0);
    check("b_after_done", {30'd0, gnt_a, gnt_b}, 32'b01);
    tick();
    req_b = 1'b0; data_b = 8'h00;
    watch(100);
    check_full_frame("bf0", 32'hF0);
    tick();
    req_a = 1'b1; data_a = 8'h3C;
    req_b = 1'b1;
    @(negedge clk);
    check("rr_alternate", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    watch(100);
    check_full_frame("a3c", 32'h3C);

    // A again with pointer on A; then B arrives mid-frame
    tick();
    req_a = 1'b1; data_a = 8'h5A;
    @(negedge clk);
    check("single_a", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    req_a = 1'b0;
    repeat (5) tick();
    req_b = 1'b1; data_b = 8'h3C;
    watch(100);
    check("mid_timeout", 32'(timed_out), 32'd0);
    check("mid_no_gnt_b", 32'(gnt_b_n), 32'd0);
    check("mid_gnt_b_idle", {30'd0, gnt_a, gnt_b}, 32'b01);
    tick();
    req_b = 1'b0; data_b = 8'hFF;
    watch(100);
    check_full_frame("b3c", 32'h3C);

    // reset during bit 3 aborts the frame
    tick();
    req_a = 1'b1; data_a = 8'hFF;
    @(negedge clk);
    check("abort_gnt", 32'(gnt_a), 32'd1);
    tick();
    req_a = 1'b0;
    repeat (12) tick();
    check("abort_pre_state", 32'(dbg_state), 32'd1);
    check("abort_pre_data", 32'(ser_data), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {25'd0, busy, ser_clk, ser_data, ser_latch, done, gnt_a, gnt_b}, 32'd0);
    rst_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || ser_latch || busy) rst_seen++;
    end
    check("abort_quiet", 32'(rst_seen), 32'd0);
    tick();
    rst_n = 1'b1;
    req_a = 1'b1; data_a = 8'h81;
    @(negedge clk);
    check("post_rst_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
    tick();
    req_a = 1'b0;
    watch(100);
    check_full_frame("a81", 32'h81);

    // 0x01: one set bit, first in LSB-first builds, last in MSB-first builds
    tick();
    req_a = 1'b1; data_a = 8'h01;
    @(negedge clk);
    check("one_gnt", 32'(gnt_a), 32'd1);
    tick();
    req_a = 1'b0;
    watch(100);
    check_full_frame("a01", 32'h01);

    // CLK_DIV=1, WIDTH=4 with 0x9
    sel = 1'b1;
    tick();
    req_a4 = 1'b1; data_a4 = 4'h9;
    @(negedge clk);
    check("w4_gnt", 32'(m_gnt_a), 32'd1);
    tick();
    req_a4 = 1'b0;
    watch(50);
    check("w4_timeout", 32'(timed_out), 32'd0);
    check("w4_busy", 32'(busy_n), 32'd9);
    check("w4_clk_trace", clk_trace, 32'b010101010);
    check("w4_latch", 32'(latch_n), 32'd1);
    check("w4_done", 32'(done_n), 32'd1);
    check("w4_done_at", 32'(done_at), 32'd9);
    push_exp(32'h9, 4);
    check_bits("w4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
